// File: rtl/and_operand_loader.sv
// Byte-stream operand loader for the 16-bit AND array: collects A then B,
// least-significant byte first, and holds the pair under a valid/ready handshake.
module and_operand_loader #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              frame_err,
  output logic [CNT_W-1:0]  op_count,
  output logic [1:0]        dbg_state
);

  localparam int K     = DATA_W / BYTE_W;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] sh_a_q;
  logic [DATA_W-1:0] sh_b_q;
  logic [DATA_W-1:0] sh_b_merged;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              op_valid_q;
  logic              frame_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              idx_last;

  // Stream handshake: a byte moves on an edge where in_valid && in_ready;
  // a pair moves on an edge where op_valid && op_ready.
  assign in_ready = (state_q != HOLD) && !rst;
  assign accept   = in_valid && in_ready;
  assign idx_last = (idx_q == IDX_W'(K - 1));

  // B as it will look once the byte arriving this cycle is written, so the
  // commit does not wait an extra cycle for the shadow register.
  always_comb begin
    sh_b_merged = sh_b_q;
    sh_b_merged[int'(idx_q)*BYTE_W +: BYTE_W] = in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            sh_a_q[int'(idx_q)*BYTE_W +: BYTE_W] <= in_byte;
            if (in_last) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end else if (idx_last) begin
              state_q <= LOAD_B;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            sh_b_q[int'(idx_q)*BYTE_W +: BYTE_W] <= in_byte;
            if (idx_last && in_last) begin
              a_q        <= sh_a_q;
              b_q        <= sh_b_merged;
              op_valid_q <= 1'b1;
              state_q    <= HOLD;
              idx_q      <= '0;
            end else if (idx_last || in_last) begin
              frame_err_q <= 1'b1;
              state_q     <= LOAD_A;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (op_valid_q && op_ready) begin
            op_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            state_q    <= LOAD_A;
            idx_q      <= '0;
          end
        end
        default: begin
          state_q <= LOAD_A;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op_valid  = op_valid_q;
  assign frame_err = frame_err_q;
  assign op_count  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_and_operand_loader.sv
// Randomized scoreboard bench for and_operand_loader: frames are modelled as
// whole {a,b} pairs, and a monitor pops and checks each consumed pair.
module tb_and_operand_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op_valid;
  logic        op_ready;
  logic        frame_err;
  logic [7:0]  op_count;
  logic [1:0]  dbg_state;

  and_operand_loader #(.DATA_W(16), .BYTE_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .a(a), .b(b),
    .op_valid(op_valid), .op_ready(op_ready), .frame_err(frame_err),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [15:0] model_a;
  logic [15:0] model_b;
  logic [7:0]  model_cnt;
  int          exp_err;

  logic [7:0]  mon_cnt;
  logic        mon_pending;
  int          err_seen;
  int          ready_mode;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    op_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) op_ready = ($urandom_range(0, 3) != 0);
      else                 op_ready = (ready_mode == 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      mon_cnt     = '0;
      mon_pending = 1'b0;
    end else begin
      if (mon_pending) begin
        chk("op_count_after_consume", op_count, mon_cnt);
        chk("op_valid_drop", op_valid, 1'b0);
        chk("in_ready_turnaround", in_ready, 1'b1);
        mon_pending = 1'b0;
      end
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair actual=%0h expected=none at %0t", {a, b}, $time);
        end else begin
          chk("pair_ab", {a, b}, exp_q.pop_front());
          mon_cnt     = mon_cnt + 8'd1;
          mon_pending = 1'b1;
        end
      end
      if (frame_err) err_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input bit last, input int max_gap);
    int gap;
    int n;
    bit ok;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_byte  = d;
    in_last  = last;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // kind 0: good frame; 1: in_last early on byte pos; 2: final byte without in_last
  task automatic send_frame(input logic [15:0] fa, input logic [15:0] fb,
                            input int kind, input int pos, input int max_gap);
    logic [7:0] bytes [4];
    int nb;
    bytes[0] = fa[7:0];
    bytes[1] = fa[15:8];
    bytes[2] = fb[7:0];
    bytes[3] = fb[15:8];
    nb = (kind == 1) ? pos + 1 : 4;
    if (kind == 0) begin
      exp_q.push_back({fa, fb});
      model_a   = fa;
      model_b   = fb;
      model_cnt = model_cnt + 8'd1;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < nb; i++)
      send_byte(bytes[i], (kind == 0 && i == 3) || (kind == 1 && i == pos), max_gap);
    if (kind == 0) begin
      chk("latency_valid", op_valid, 1'b1);
      chk("latency_ab", {a, b}, {fa, fb});
    end else begin
      chk("bad_frame_no_valid", op_valid, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 at %0t", exp_q.size(), $time);
    end
  endtask

  task automatic checkpoint(input string name);
    drain();
    chk({name, "_a"}, a, model_a);
    chk({name, "_b"}, b, model_b);
    chk({name, "_count"}, op_count, model_cnt);
    chk({name, "_frame_err_pulses"}, err_seen, exp_err);
    chk({name, "_op_valid"}, op_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_a   = '0;
    model_b   = '0;
    model_cnt = '0;
    chk("rst_a", a, 16'h0);
    chk("rst_b", b, 16'h0);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_op_count", op_count, 8'h0);
    chk("rst_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] hold_a;
    logic [15:0] hold_b;
    rst        = 1'b1;
    in_byte    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    ready_mode = 0;
    exp_err    = 0;
    err_seen   = 0;
    mon_cnt    = '0;
    mon_pending = 1'b0;
    model_a    = '0;
    model_b    = '0;
    model_cnt  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // basic frame, downstream always ready
    ready_mode = 1;
    send_frame(16'h1234, 16'hABCD, 0, 0, 0);
    checkpoint("basic");

    // downstream stalls for 10 cycles
    ready_mode = 0;
    @(posedge clk);
    #3;
    send_frame(16'h1234, 16'hABCD, 0, 0, 0);
    hold_a = a;
    hold_b = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_op_valid", op_valid, 1'b1);
      chk("hold_ab", {a, b}, {hold_a, hold_b});
      chk("hold_in_ready", in_ready, 1'b0);
    end
    checkpoint("stall");

    // early in_last on byte 2, then a good frame
    send_frame(16'h5555, 16'h6666, 1, 1, 0);
    checkpoint("early_last");
    send_frame(16'h00FF, 16'hF00F, 0, 0, 0);
    checkpoint("after_early");

    // final byte without in_last, then a good frame
    send_frame(16'($urandom), 16'($urandom), 2, 0, 0);
    checkpoint("missing_last");
    send_frame(16'($urandom), 16'($urandom), 0, 0, 0);
    checkpoint("after_missing");

    // in_valid toggled within the frame
    send_frame(16'h0201, 16'h0403, 0, 0, 3);
    checkpoint("gappy");

    // randomized mix of good and bad frames with random op_ready
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int kind;
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(16'($urandom), 16'($urandom), kind, int'($urandom_range(0, 2)), 2);
    end
    checkpoint("random_mix");

    // reset in LOAD_B, then reset in HOLD
    ready_mode = 0;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    chk("mid_frame_state_load_b", dbg_state, 2'd1);
    do_reset();
    send_frame(16'hBEEF, 16'hCAFE, 0, 0, 0);
    do_reset();
    checkpoint("after_resets");

    // 256 back-to-back frames wrap the counter
    ready_mode = 1;
    @(posedge clk);
    #3;
    for (int f = 0; f < 256; f++)
      send_frame(16'($urandom), 16'($urandom), 0, 0, 0);
    checkpoint("wrap");
    chk("wrap_count_zero", op_count, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
